// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter and its users.
// State encodings plus the channel ids the cpu top wires up.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam int CH_MEM   = 0;
    localparam int CH_FETCH = 1;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_grant.sv
// Combinational grant picker: round-robin from a pointer, or fixed
// lowest-index priority when MEM_ARBITER_FIXED_PRIO_EN is defined.
module mem_arbiter_rr_grant #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx
);

    logic [NUM_CH-1:0] w_pick;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
    assign w_pick = i_req;
`else
    logic [NUM_CH-1:0] w_hi;
    // Requests at or above the pointer win first; otherwise wrap to the bottom.
    assign w_hi   = i_req & ~((NUM_CH'(1) << i_ptr) - NUM_CH'(1));
    assign w_pick = (|w_hi) ? w_hi : i_req;
`endif

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_pick[k]) begin
                o_gnt    = '0;
                o_gnt[k] = 1'b1;
                o_idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel single-port RAM arbiter, one transaction in flight at a time.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_data_in,
    output logic                     mem_write_enable,
    input  logic [DATA_W-1:0]        mem_data_out,
    output logic                     busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    arb_state_t r_state;
    arb_state_t w_next;

    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr  [NUM_CH];
    logic [DATA_W-1:0] w_wdata [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    mem_arbiter_rr_grant #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_grant (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_accept  = (r_state == ARB_IDLE) && !rst && (|req_valid);
    assign req_ready = w_accept ? w_gnt : '0;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ARB_IDLE:  if (|req_valid) w_next = ARB_ISSUE;
            ARB_ISSUE: w_next = (MEM_LAT > 1) ? ARB_WAIT : ARB_RESP;
            ARB_WAIT:  if (r_cnt == CNT_W'(1)) w_next = ARB_RESP;
            ARB_RESP:  w_next = ARB_IDLE;
            default:   w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_id    <= w_idx;
                r_we    <= req_we[w_idx];
                r_addr  <= w_addr[w_idx];
                r_wdata <= w_wdata[w_idx];
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                r_ptr   <= IDX_W'(wrap_inc(int'(w_idx), NUM_CH));
`endif
            end
            if (r_state == ARB_ISSUE) begin
                r_cnt <= CNT_W'(MEM_LAT - 1);
            end else if (r_state == ARB_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Write strobe decodes ISSUE directly, so a write issued alongside rst still lands.
    assign mem_write_enable = (r_state == ARB_ISSUE) && r_we;
    assign mem_address      = r_addr;
    assign mem_data_in      = r_wdata;
    assign rsp_valid        = (r_state == ARB_RESP) ? (NUM_CH'(1) << r_id) : '0;
    assign rsp_rdata        = mem_data_out;
    assign busy             = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two configs (2ch/lat1, 4ch/lat3),
// directed scenarios then random traffic with random reset pulses.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        int          ch;
        bit          we;
        logic [31:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        int          ch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          start;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit done [2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pre_val(input int i);
        if (i == 8'h10) return 32'hDEADBEEF;
        return (32'h0101_0101 * 32'(i)) ^ 32'h5A5A_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int N = (g == 0) ? 2 : 4;
        localparam int L = (g == 0) ? 1 : 3;

        logic          rst = 1'b1;
        logic [N-1:0]  rv  = '0;
        logic [N-1:0]  rwe = '0;
        logic [N-1:0]  rr;
        logic [N-1:0]  rspv;
        logic [N*32-1:0] ra = '0;
        logic [N*32-1:0] rd = '0;
        logic [31:0]   rdata, maddr, mdin, mdout;
        logic          mwe, busy;
        logic [31:0]   ram  [256];
        logic [31:0]   pipe [L];

        rsp_t        sb[$];
        int          obs[$];
        int          free_at  = 0;
        int          mwe_cyc  = -1;
        int          iss_cyc  = -1;
        logic [31:0] exp_addr = '0;
        logic [31:0] exp_wd   = '0;

        mem_arbiter #(
            .NUM_CH  (N),
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (L)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .req_valid        (rv),
            .req_ready        (rr),
            .req_we           (rwe),
            .req_addr         (ra),
            .req_wdata        (rd),
            .rsp_valid        (rspv),
            .rsp_rdata        (rdata),
            .mem_address      (maddr),
            .mem_data_in      (mdin),
            .mem_write_enable (mwe),
            .mem_data_out     (mdout),
            .busy             (busy)
        );

        // Synchronous RAM with L-cycle read latency.
        always @(posedge clk) begin
            if (cyc == 0) begin
                for (int i = 0; i < 256; i++) ram[i] <= pre_val(i);
            end else if (mwe === 1'b1) begin
                ram[maddr[7:0]] <= mdin;
            end
            pipe[0] <= ram[maddr[7:0]];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mdout = pipe[L-1];

        initial begin : mon
            int   k;
            rsp_t e;
            forever begin
                @(negedge clk);
                k = cyc;
                chk($sformatf("cfg%0d.busy", g), 64'(busy), 64'(k < free_at));
                chk($sformatf("cfg%0d.mem_we", g), 64'(mwe), 64'(k == mwe_cyc));
                if (k == iss_cyc) begin
                    chk($sformatf("cfg%0d.mem_addr", g), 64'(maddr), 64'(exp_addr));
                    if (k == mwe_cyc)
                        chk($sformatf("cfg%0d.mem_wdata", g), 64'(mdin), 64'(exp_wd));
                end
                if (k <= 2) begin
                    chk($sformatf("cfg%0d.rst_addr", g), 64'(maddr), 64'(0));
                    chk($sformatf("cfg%0d.rst_wdata", g), 64'(mdin), 64'(0));
                end
                if (sb.size() > 0 && sb[0].due == k) begin
                    e = sb.pop_front();
                    chk($sformatf("cfg%0d.rsp_valid", g), 64'(rspv), 64'(1) << e.ch);
                    if (!e.we)
                        chk($sformatf("cfg%0d.rsp_rdata", g), 64'(rdata), 64'(e.data));
                    obs.push_back(int'(rspv));
                end else begin
                    chk($sformatf("cfg%0d.rsp_idle", g), 64'(rspv), 64'(0));
                end
            end
        end

        initial begin : stim
            logic [31:0] mem_m [256];
            req_t        dq[$];
            req_t        pend [N];
            bit          pv [N];
            req_t        r;
            int          k, w, c, mptr, npend;
            int          exp_o [4];
            bit          rnd;

            for (int i = 0; i < 256; i++) mem_m[i] = pre_val(i);
            for (int i = 0; i < N; i++) begin
                pend[i] = '{i, 1'b0, 32'h0, 32'h0, 0};
                pv[i]   = 1'b0;
            end
            if (g == 0) begin
                dq.push_back('{CH_MEM, 1'b1, 32'h20, 32'h1234_5678, 4});
                dq.push_back('{CH_MEM, 1'b0, 32'h20, 32'h0, 4});
                dq.push_back('{CH_FETCH, 1'b0, 32'h10, 32'h0, 12});
                for (int j = 0; j < 4; j++) begin
                    dq.push_back('{0, 1'b0, 32'(j * 8), 32'h0, 20});
                    dq.push_back('{1, 1'b0, 32'(j * 8 + 4), 32'h0, 20});
                end
            end else begin
                dq.push_back('{3, 1'b0, 32'h10, 32'h0, 4});
                for (int j = 0; j < 3; j++)
                    dq.push_back('{j, 1'b0, 32'(j * 4), 32'h0, 7});
            end
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            exp_o = '{0, 0, 0, 0};
`else
            exp_o = '{0, 1, 0, 1};
`endif
            mptr = 0;

            forever begin
                @(negedge clk);
                k   = cyc;
                rnd = (k > 60) && (k < 600);
                rst = (k <= 2) || (rnd && $urandom_range(0, 39) == 0);

                for (int i = 0; i < N; i++) begin
                    if (!pv[i]) begin
                        for (int j = 0; j < dq.size(); j++) begin
                            if (dq[j].ch == i && dq[j].start <= k) begin
                                pend[i] = dq[j];
                                pv[i]   = 1'b1;
                                dq.delete(j);
                                break;
                            end
                        end
                        if (!pv[i] && rnd && $urandom_range(0, 3) == 0) begin
                            pend[i] = '{i, 1'($urandom_range(0, 1)),
                                        ($urandom & 32'hFFFF_FF00) |
                                        32'($urandom_range(0, 15) * 4),
                                        $urandom, k};
                            pv[i] = 1'b1;
                        end
                    end else if (rnd && $urandom_range(0, 15) == 0) begin
                        pv[i] = 1'b0;
                    end
                    rv[i]            = pv[i];
                    rwe[i]           = pend[i].we;
                    ra[i*32 +: 32]   = pend[i].addr;
                    rd[i*32 +: 32]   = pend[i].data;
                end

                #1;
                w = -1;
                if (!rst && k >= free_at) begin
                    for (int j = 0; j < N; j++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
                        c = j;
`else
                        c = (mptr + j) % N;
`endif
                        if (w < 0 && pv[c]) w = c;
                    end
                end
                chk($sformatf("cfg%0d.req_ready", g), 64'(rr),
                    (w < 0) ? 64'(0) : (64'(1) << w));

                if (w >= 0) begin
                    r = pend[w];
                    sb.push_back('{w, r.we, mem_m[r.addr[7:0]], k + 1 + L});
                    if (r.we) begin
                        mem_m[r.addr[7:0]] = r.data;
                        mwe_cyc = k + 1;
                    end
                    iss_cyc  = k + 1;
                    exp_addr = r.addr;
                    exp_wd   = r.data;
                    free_at  = k + 2 + L;
                    mptr     = (w + 1) % N;
                    pv[w]    = 1'b0;
                end

                if (rst) begin
                    while (sb.size() > 0 && sb[sb.size()-1].due > k) void'(sb.pop_back());
                    if (mwe_cyc > k) mwe_cyc = -1;
                    if (iss_cyc > k) iss_cyc = -1;
                    if (free_at > k + 1) free_at = k + 1;
                    mptr = 0;
                end

                if (g == 0 && k == 50) begin
                    chk("cfg0.grant_count", 64'(obs.size() >= 7), 64'(1));
                    for (int j = 0; j < 4; j++)
                        chk($sformatf("cfg0.grant_order%0d", j),
                            64'((obs.size() > 3 + j) ? obs[3 + j] : -1),
                            64'(1) << exp_o[j]);
                end

                npend = 0;
                for (int i = 0; i < N; i++) npend += int'(pv[i]);
                if (k >= 600 && npend == 0 && dq.size() == 0 &&
                    sb.size() == 0 && k >= free_at) break;
                if (k >= 1500) begin
                    chk($sformatf("cfg%0d.drain", g), 64'(npend + sb.size()), 64'(0));
                    break;
                end
            end
            done[g] = 1'b1;
        end
    end

    initial begin : top
        int t;
        for (t = 0; t < 3000 && !(done[0] && done[1]); t++) @(posedge clk);
        if (!(done[0] && done[1])) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: done=%0d%0d, want 11", done[0], done[1]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
